countdown_timer: RTL



---
 rtl/countdown_timer_pkg.sv | 28 ++
 rtl/countdown_timer_tick_prescaler.sv | 34 +++
 rtl/countdown_timer.sv | 97 +++++++++
 3 files changed

// File: rtl/countdown_timer_pkg.sv
// Shared timing definitions for the countdown timer and its prescaler.
// Latency: n/a (types, constants and an elaboration-time helper only).
// Backpressure: n/a.
package countdown_timer_pkg;

    // Time-unit encodings for SELECT_UNITS
    localparam int UNITS_MS     = 0;
    localparam int UNITS_US     = 1;
    localparam int UNITS_CYCLES = 2;

    // Countdown FSM states
    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    // Clocks per time unit; returns 0 for an unknown unit so the caller
    // can reject it at elaboration together with a too-slow clock.
    function automatic int calc_div(input int freq_in, input int select_units);
        case (select_units)
            UNITS_MS:     return freq_in / 1000;
            UNITS_US:     return freq_in / 1000000;
            UNITS_CYCLES: return 1;
            default:      return 0;
        endcase
    endfunction

endpackage

// File: rtl/countdown_timer_tick_prescaler.sv
// Divides the clock into one-cycle ticks every DIV enabled cycles.
// Latency: tick is combinational from the count and enable (DIV-1 enabled cycles after clear).
// Backpressure: enable low freezes the count; clear restarts it from 0.
module tick_prescaler #(
    parameter int DIV = 1
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    output logic tick
);

    localparam int            PW   = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [PW-1:0] LAST = PW'(DIV - 1);

    logic [PW-1:0] cnt;

    assign tick = enable && (cnt == LAST);

    // Prescaler count: clear wins, then wrap on tick, else advance while enabled
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (clear) begin
            cnt <= '0;
        end else if (tick) begin
            cnt <= '0;
        end else if (enable) begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/countdown_timer.sv
// Programmable countdown: loads a count and decrements it once per time unit, pulsing done at zero.
// Latency: done rises V*DIV clocks after a load of V>0 (1 clock for a load of 0).
// Backpressure: enableTimerCounter low freezes prescaler and count; busy stays high.
module countdown_timer
    import countdown_timer_pkg::*;
#(
    parameter  int FREQ_IN           = 12000000,
    parameter  int LIMIT_COUNT_TIMER = 1000,
    parameter  int SELECT_UNITS      = 0,
    localparam int W                 = $clog2(LIMIT_COUNT_TIMER + 1)
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         loadTimer,
    input  logic [W-1:0] loadValue,
    input  logic         enableTimerCounter,
    output logic [W-1:0] remainingTimer,
    output logic         busy,
    output logic         done
);

    localparam int           DIV   = calc_div(FREQ_IN, SELECT_UNITS);
    localparam logic [W-1:0] LIMIT = W'(LIMIT_COUNT_TIMER);

    if (SELECT_UNITS != UNITS_MS && SELECT_UNITS != UNITS_US && SELECT_UNITS != UNITS_CYCLES) begin : g_bad_units
        $error("countdown_timer: unsupported SELECT_UNITS value");
    end
    if (DIV < 1) begin : g_bad_div
        $error("countdown_timer: FREQ_IN too low for the selected time unit");
    end

    state_t       state, next_state;
    logic [W-1:0] next_remaining;
    logic         next_done;
    logic [W-1:0] clamped;
    logic         run_enable;
    logic         tick;

    assign clamped    = (loadValue > LIMIT) ? LIMIT : loadValue;
    assign run_enable = enableTimerCounter && (state == ST_RUN);
    assign busy       = (state == ST_RUN);

    // A load always restarts the time base, so a tick colliding with a reload is lost
    tick_prescaler #(
        .DIV(DIV)
    ) u_prescaler (
        .clk   (clk),
        .rst   (rst),
        .clear (loadTimer),
        .enable(run_enable),
        .tick  (tick)
    );

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next state and datapath: load beats tick; decrement only when the count is non-zero
    always_comb begin
        next_state     = state;
        next_remaining = remainingTimer;
        next_done      = 1'b0;
        if (loadTimer) begin
            if (clamped == '0) begin
                next_state     = ST_IDLE;
                next_remaining = '0;
                next_done      = 1'b1;
            end else begin
                next_state     = ST_RUN;
                next_remaining = clamped;
            end
        end else if (state == ST_RUN && tick && remainingTimer != '0) begin
            next_remaining = remainingTimer - 1'b1;
            if (remainingTimer == W'(1)) begin
                next_state = ST_IDLE;
                next_done  = 1'b1;
            end
        end
    end

    // Registered count and expiry pulse
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            remainingTimer <= '0;
            done           <= 1'b0;
        end else begin
            remainingTimer <= next_remaining;
            done           <= next_done;
        end
    end

endmodule
